// File: rtl/neo_f1_pkg.sv
// Shared definitions for the NEO F1 I/O block: register addresses and the
// RTC serial engine state type.
package neo_f1_pkg;

  // Register select values, as seen on M68K_ADDR[7:4]
  localparam logic [3:0] ADDR_SLOT       = 4'h2;
  localparam logic [3:0] ADDR_LED_STB    = 4'h3;
  localparam logic [3:0] ADDR_LED_DATA   = 4'h4;
  localparam logic [3:0] ADDR_RTC_DIRECT = 4'h5;
  localparam logic [3:0] ADDR_RTC_CMD    = 4'h6;

  // Number of command bits shifted out to the RTC per command
  localparam int RTC_CMD_BITS = 4;

  // RTC command engine states
  typedef enum logic [1:0] {
    RTC_IDLE,
    RTC_SETUP,
    RTC_HIGH,
    RTC_STROBE
  } rtc_state_t;

endpackage

// File: rtl/neo_f1_rtc_ser.sv
// RTC command serialiser: shifts a 4-bit command out LSB first, each bit as
// a SETUP phase (data valid, clock low) followed by a HIGH phase (clock
// high), then closes with a STROBE phase. Every phase lasts RTC_DIV cycles.
module neo_f1_rtc_ser #(
  parameter int RTC_DIV = 8
) (
  input  logic       i_clk,
  input  logic       i_nReset,
  input  logic       i_start,
  input  logic [3:0] i_data,
  output logic       o_busy,
  output logic       o_rtcDin,
  output logic       o_rtcClk,
  output logic       o_rtcStrobe
);
  import neo_f1_pkg::*;

  localparam int DW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;

  rtc_state_t r_state;
  rtc_state_t w_next;
  logic [DW-1:0] r_div;
  logic [1:0]    r_bit;
  logic [3:0]    r_data;
  logic          w_phaseDone;

  assign w_phaseDone = (r_div == DW'(RTC_DIV - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) r_state <= RTC_IDLE;
    else           r_state <= w_next;
  end

  // Phase timer, bit index and captured command; timer restarts on every state change
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_data <= '0;
    end else begin
      if (r_state == RTC_IDLE) begin
        r_div <= '0;
        if (i_start) begin
          r_data <= i_data;
          r_bit  <= '0;
        end
      end else if (w_next != r_state) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (r_state == RTC_HIGH && w_phaseDone) r_bit <= r_bit + 1'b1;
    end
  end

  // Next-state: each phase ends when its timer reaches RTC_DIV-1
  always_comb begin
    w_next = r_state;
    case (r_state)
      RTC_IDLE:   if (i_start) w_next = RTC_SETUP;
      RTC_SETUP:  if (w_phaseDone) w_next = RTC_HIGH;
      RTC_HIGH:   if (w_phaseDone) w_next = (r_bit == 2'(RTC_CMD_BITS - 1)) ? RTC_STROBE : RTC_SETUP;
      RTC_STROBE: if (w_phaseDone) w_next = RTC_IDLE;
      default:    w_next = RTC_IDLE;
    endcase
  end

  // Outputs: data bit held through both halves of its clock period
  always_comb begin
    o_busy      = (r_state != RTC_IDLE);
    o_rtcDin    = 1'b0;
    o_rtcClk    = 1'b0;
    o_rtcStrobe = 1'b0;
    case (r_state)
      RTC_SETUP:  o_rtcDin = r_data[r_bit];
      RTC_HIGH: begin
        o_rtcDin = r_data[r_bit];
        o_rtcClk = 1'b1;
      end
      RTC_STROBE: o_rtcStrobe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/neo_f1_io.sv
// NEO F1 I/O block: 68k-written slot select, LED latch strobes and data,
// RTC serial control, plus the DIP/status read multiplexer.
// Build option: define RTC_AUTO_EN to include the RTC command engine
// (register 0x6); without it the RTC lines are only driven directly.
module neo_f1_io #(
  parameter int NUM_SLOTS = 6,
  parameter int LED_CH    = 3,
  parameter int LED_PULSE = 4,
  parameter int RTC_DIV   = 8
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 nBITW0,
  input  logic                 nDIPRD0,
  input  logic                 nDIPRD1,
  input  logic [7:4]           M68K_ADDR,
  input  logic [7:0]           M68K_DIN,
  output logic [7:0]           M68K_DOUT,
  output logic                 M68K_DOE,
  input  logic [7:0]           DIPSW,
  input  logic                 SYSTEMB,
  input  logic                 TEST,
  input  logic                 SERVICE,
  input  logic                 TYPE_A,
  input  logic                 TYPE_B,
  input  logic [3:0]           COINS,
  output logic [NUM_SLOTS-1:0] nSLOT,
  output logic [2:0]           SLOT_SEL,
  output logic [LED_CH-1:0]    LED_LATCH,
  output logic [7:0]           LED_DATA,
  input  logic                 RTC_DOUT,
  input  logic                 RTC_TP,
  output logic                 RTC_DIN,
  output logic                 RTC_CLK,
  output logic                 RTC_STROBE
);
  import neo_f1_pkg::*;

  localparam int PCW = $clog2(LED_PULSE + 1);

  logic           r_bitwMeta;
  logic           r_bitwSync;
  logic           r_bitwPrev;
  logic [2:0]     r_syncValid;
  logic           w_commit;
  logic [2:0]     r_slot;
  logic [LED_CH-1:0] r_ledLatch;
  logic [PCW-1:0] r_pulseCnt;
  logic [7:0]     r_ledData;
  logic [2:0]     r_rtcDirect;
  logic           w_rtcBusy;
  logic           w_cmdStart;
  logic           w_serDin;
  logic           w_serClk;
  logic           w_serStrobe;

  // Two-flop synchroniser for the write strobe plus edge history. The valid
  // pipe keeps a strobe that was already low during reset from looking like
  // a fresh falling edge once reset lifts.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_bitwMeta  <= 1'b1;
      r_bitwSync  <= 1'b1;
      r_bitwPrev  <= 1'b1;
      r_syncValid <= '0;
    end else begin
      r_bitwMeta  <= nBITW0;
      r_bitwSync  <= r_bitwMeta;
      r_bitwPrev  <= r_bitwSync;
      r_syncValid <= {r_syncValid[1:0], 1'b1};
    end
  end

  assign w_commit = r_syncValid[2] & r_bitwPrev & ~r_bitwSync;

  // Slot register and LED data register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_slot    <= '0;
      r_ledData <= '0;
    end else if (w_commit) begin
      if (M68K_ADDR == ADDR_SLOT)     r_slot    <= M68K_DIN[2:0];
      if (M68K_ADDR == ADDR_LED_DATA) r_ledData <= M68K_DIN;
    end
  end

  // LED strobe pulse: a new strobe always reloads the mask and the width
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_ledLatch <= '0;
      r_pulseCnt <= '0;
    end else if (w_commit && M68K_ADDR == ADDR_LED_STB) begin
      r_ledLatch <= M68K_DIN[3 +: LED_CH];
      r_pulseCnt <= PCW'(LED_PULSE);
    end else if (r_pulseCnt != '0) begin
      r_pulseCnt <= r_pulseCnt - 1'b1;
      if (r_pulseCnt == PCW'(1)) r_ledLatch <= '0;
    end
  end

`ifdef RTC_AUTO_EN
  assign w_cmdStart = w_commit && (M68K_ADDR == ADDR_RTC_CMD) && !w_rtcBusy;

  neo_f1_rtc_ser #(
    .RTC_DIV(RTC_DIV)
  ) u_rtcSer (
    .i_clk       (CLK),
    .i_nReset    (nRESET),
    .i_start     (w_cmdStart),
    .i_data      (M68K_DIN[3:0]),
    .o_busy      (w_rtcBusy),
    .o_rtcDin    (w_serDin),
    .o_rtcClk    (w_serClk),
    .o_rtcStrobe (w_serStrobe)
  );
`else
  assign w_cmdStart  = 1'b0;
  assign w_rtcBusy   = 1'b0;
  assign w_serDin    = 1'b0;
  assign w_serClk    = 1'b0;
  assign w_serStrobe = 1'b0;
`endif

  // Direct RTC pin register {STROBE,CLK,DIN}; cleared when a command starts
  // so the lines fall back to 0 after the engine finishes
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_rtcDirect <= '0;
    end else if (w_cmdStart) begin
      r_rtcDirect <= '0;
    end else if (w_commit && M68K_ADDR == ADDR_RTC_DIRECT && !w_rtcBusy) begin
      r_rtcDirect <= M68K_DIN[2:0];
    end
  end

  assign RTC_DIN    = w_rtcBusy ? w_serDin    : r_rtcDirect[0];
  assign RTC_CLK    = w_rtcBusy ? w_serClk    : r_rtcDirect[1];
  assign RTC_STROBE = w_rtcBusy ? w_serStrobe : r_rtcDirect[2];

  assign LED_LATCH = r_ledLatch;
  assign LED_DATA  = r_ledData;
  assign SLOT_SEL  = SYSTEMB ? r_slot : 3'd0;

  // One-hot-low slot select; out-of-range slot values select nothing
  always_comb begin
    nSLOT = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SYSTEMB && r_slot == 3'(i)) nSLOT[i] = 1'b0;
    end
  end

  assign M68K_DOE = !nDIPRD0 || !nDIPRD1;

  // Read multiplexer; the second read port wins when both are enabled
  always_comb begin
    M68K_DOUT = 8'h00;
    if (!nDIPRD1) begin
      M68K_DOUT = {RTC_DOUT, RTC_TP, TYPE_B, COINS[3:2], SERVICE, COINS[1:0]};
    end else if (!nDIPRD0) begin
      M68K_DOUT = M68K_ADDR[7] ? {TEST, TYPE_A, 5'b00000, w_rtcBusy} : DIPSW;
    end
  end

endmodule

// File: doc/neo_f1_io.md
NEO_F1_IO -- requirements
Module: neo_f1_io

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 6, number of cartridge slots decoded (range 1..8).
REQ-002 SHALL have parameter LED_CH, default 3, number of LED latch strobe lines.
REQ-003 SHALL have parameter LED_PULSE, default 4, LED strobe width in CLK cycles (>=1).
REQ-004 SHALL have parameter RTC_DIV, default 8, CLK cycles per RTC serial phase (>=2).
REQ-005 SHALL have port CLK  in  1  system clock; all state on rising edge.
REQ-006 SHALL have port nRESET  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port nBITW0  in  1  68k write strobe, active low, asynchronous to CLK.
REQ-008 SHALL have ports nDIPRD0, nDIPRD1  in  1 each  read enables, active low.
REQ-009 SHALL have ports M68K_ADDR  in  4 (bits 7:4)  register select; M68K_DIN  in  8  write data.
REQ-010 SHALL have ports M68K_DOUT  out  8  read data; M68K_DOE  out  1  read-data drive enable.
REQ-011 SHALL have ports DIPSW  in  8; SYSTEMB, TEST, SERVICE, TYPE_A, TYPE_B  in  1 each; COINS  in  4.
REQ-012 SHALL have ports nSLOT  out  NUM_SLOTS  one-hot-low slot select; SLOT_SEL  out  3  encoded slot.
REQ-013 SHALL have ports LED_LATCH  out  LED_CH  strobes; LED_DATA  out  8  LED data.
REQ-014 SHALL have ports RTC_DOUT, RTC_TP  in  1 each; RTC_DIN, RTC_CLK, RTC_STROBE  out  1 each.

Function
REQ-015 SHALL synchronise nBITW0 through two flops and commit a write on the cycle after the detected falling edge, using M68K_ADDR/M68K_DIN sampled that cycle; exactly one commit per strobe.
REQ-016 SHALL decode commits by M68K_ADDR: 0x2 slot register <= DIN[2:0]; 0x3 LED strobe; 0x4 LED_DATA <= DIN; 0x5 RTC direct {STROBE,CLK,DIN} <= DIN[2:0]; 0x6 RTC command; other addresses ignored.
REQ-017 SHALL drive nSLOT[i]=0 only when SYSTEMB=1 and slot register == i; slot register >= NUM_SLOTS or SYSTEMB=0 gives all ones.
REQ-018 SHALL drive SLOT_SEL = slot register when SYSTEMB=1, else 0.
REQ-019 SHALL, on an LED strobe commit, raise LED_LATCH bits where DIN[3+k]=1 for exactly LED_PULSE cycles, then return them to 0; a new strobe commit mid-pulse restarts the count with the new mask.
REQ-020 SHALL implement RTC command engine states IDLE, SETUP, HIGH, STROBE; RTC_BUSY=1 in all but IDLE.
REQ-021 SHALL, on a command commit in IDLE, shift DIN[3:0] LSB first: per bit SETUP (RTC_DIN=bit, RTC_CLK=0) RTC_DIV cycles, then HIGH (RTC_CLK=1) RTC_DIV cycles; after bit 3, STROBE (RTC_STROBE=1, RTC_CLK=0) RTC_DIV cycles, then IDLE with RTC outputs 0; total 9*RTC_DIV cycles.
REQ-022 SHALL ignore RTC command and RTC direct commits while RTC_BUSY=1.
REQ-023 SHALL, with nDIPRD0=0: M68K_DOUT = ADDR[7] ? {TEST, TYPE_A, 5'b0, RTC_BUSY} : DIPSW.
REQ-024 SHALL, with nDIPRD1=0: M68K_DOUT = {RTC_DOUT, RTC_TP, TYPE_B, COINS[3:2], SERVICE, COINS[1:0]}; nDIPRD1 has priority when both low.
REQ-025 SHALL assert M68K_DOE combinationally iff nDIPRD0=0 or nDIPRD1=0; M68K_DOUT=0 otherwise.

Reset
REQ-026 SHALL, while nRESET=0, clear slot register, LED_DATA, LED_LATCH, pulse counter, RTC outputs, engine to IDLE, synchroniser flops to 1.
REQ-027 SHALL abort an in-flight RTC command or LED pulse immediately on reset; no commit for a strobe falling during reset.

Configuration
REQ-028 SHALL compile the RTC command engine (REQ-020..022, address 0x6) only when RTC_AUTO_EN is defined.
REQ-029 SHALL, without RTC_AUTO_EN, ignore address 0x6, tie RTC_BUSY to 0, and accept direct RTC writes always.

Structure
REQ-030 SHALL place register address constants and the RTC state enum in shared package neo_f1_pkg.
REQ-031 SHALL implement the command engine as sub-module neo_f1_rtc_ser (parameter RTC_DIV).

Verification
REQ-032 SHALL check: SYSTEMB=1, write 0x2 DIN=0x03 -> nSLOT=6'b110111, SLOT_SEL=3; DIN=0x07 -> nSLOT=6'b111111.
REQ-033 SHALL check: write 0x3 DIN=0x28 -> LED_LATCH=3'b101 for exactly 4 cycles then 0; rewrite mid-pulse restarts count.
REQ-034 SHALL check (RTC_AUTO_EN): write 0x6 DIN=0x05 -> RTC_DIN sequence 1,0,1,0, 4 RTC_CLK pulses of 8 cycles, STROBE 8 cycles, RTC_BUSY read as 1 for 72 cycles.
REQ-035 SHALL check: second command or 0x5 write during busy -> no output change; after IDLE, 0x5 DIN=0x06 -> RTC_CLK=1, RTC_STROBE=1.
REQ-036 SHALL check: nRESET low mid-command -> all RTC outputs 0, RTC_BUSY=0, nSLOT all ones, LED_DATA=0.
REQ-037 SHALL check: nDIPRD0 low ADDR=0x8, TEST=1, TYPE_A=0 -> M68K_DOUT=0x80, DOE=1; both reads low -> status-A value.
